// File: rtl/voice_allocator.sv
// Three-slot polyphony allocator: accepts note events, keeps an age-ordered voice table and
// publishes compacted periods. Optional sustain pedal support under VOICE_ALLOCATOR_SUSTAIN_EN.
module voice_allocator #(
    parameter int NVOICE = 3,
    parameter int KEYW   = 7,
    parameter int PRDW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ev_valid,
    output logic            ev_ready,
    input  logic            ev_on,
    input  logic [KEYW-1:0] ev_key,
    input  logic [PRDW-1:0] ev_period,
    input  logic            all_off,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    input  logic            sustain,
`endif
    output logic [PRDW-1:0] prd1,
    output logic [PRDW-1:0] prd2,
    output logic [PRDW-1:0] prd3,
    output logic [1:0]      notes,
    output logic            steal,
    output logic            busy
);

    // Handshake: an event transfers on a rising clk edge where ev_valid && ev_ready;
    // ev_valid may be raised at any time, ev_ready is high only in IDLE with no panic pending.
    typedef enum logic [1:0] {IDLE, APPLY, COMPACT} state_t;

    state_t          state;
    logic            ready_q;
    logic            slot_v   [NVOICE];
    logic [KEYW-1:0] slot_key [NVOICE];
    logic [PRDW-1:0] slot_per [NVOICE];
    logic [1:0]      slot_age [NVOICE];

    logic            cap_on;
    logic [KEYW-1:0] cap_key;
    logic [PRDW-1:0] cap_per;
    logic            steal_pend;

    logic            n_v   [NVOICE];
    logic [KEYW-1:0] n_key [NVOICE];
    logic [PRDW-1:0] n_per [NVOICE];
    logic [1:0]      n_age [NVOICE];
    logic            n_steal;

    logic [PRDW-1:0] c_prd [NVOICE];
    logic [1:0]      c_cnt;

    int              hit_idx, free_idx, vic_idx, tgt, pk;
    logic            hit, free;
    logic [1:0]      old_age;

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic            slot_held [NVOICE];
    logic            n_held    [NVOICE];
    logic            cap_sus, cap_rel, sus_q, rel_pend;
    logic            hv_found;
    logic [1:0]      hv_age, rel_dec;
    logic            accept;
    assign ev_ready = ready_q & ~all_off & ~rel_pend;
`else
    logic            accept;
    assign ev_ready = ready_q & ~all_off;
`endif

    assign accept = ev_valid & ev_ready;
    assign busy   = (state != IDLE);

    // Next slot table, computed from the captured event and committed on the APPLY edge.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = 0;
        free     = 1'b0;
        free_idx = 0;
        vic_idx  = 0;
        tgt      = 0;
        old_age  = 2'd0;
        n_steal  = 1'b0;
        c_cnt    = 2'd0;
        for (int i = 0; i < NVOICE; i++) begin
            n_v[i]   = slot_v[i];
            n_key[i] = slot_key[i];
            n_per[i] = slot_per[i];
            n_age[i] = slot_age[i];
            c_cnt    = c_cnt + {1'b0, slot_v[i]};
            if (slot_v[i] && slot_key[i] == cap_key && !hit) begin
                hit     = 1'b1;
                hit_idx = i;
            end
            if (slot_age[i] == 2'(NVOICE - 1)) vic_idx = i;
        end
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (!slot_v[i]) begin
                free     = 1'b1;
                free_idx = i;
            end
        end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        hv_found = 1'b0;
        hv_age   = 2'd0;
        rel_dec  = 2'd0;
        for (int i = 0; i < NVOICE; i++) begin
            n_held[i] = slot_held[i];
            if (slot_v[i] && slot_held[i] && (!hv_found || slot_age[i] > hv_age)) begin
                hv_found = 1'b1;
                hv_age   = slot_age[i];
                vic_idx  = i;
            end
        end
        if (cap_rel) begin
            for (int i = 0; i < NVOICE; i++) begin
                if (slot_v[i] && slot_held[i]) begin
                    n_v[i]    = 1'b0;
                    n_held[i] = 1'b0;
                end else if (slot_v[i]) begin
                    rel_dec = 2'd0;
                    for (int j = 0; j < NVOICE; j++)
                        if (slot_v[j] && slot_held[j] && slot_age[j] < slot_age[i])
                            rel_dec = rel_dec + 2'd1;
                    n_age[i] = slot_age[i] - rel_dec;
                end
            end
        end else
`endif
        if (cap_on) begin
            if (cap_per != '0) begin
                if (hit) begin
                    tgt     = hit_idx;
                    old_age = slot_age[hit_idx];
                end else if (free) begin
                    tgt     = free_idx;
                    old_age = c_cnt;
                end else begin
                    tgt     = vic_idx;
                    old_age = slot_age[vic_idx];
                    n_steal = 1'b1;
                end
                // Only voices newer than the refreshed slot's old position grow older.
                for (int i = 0; i < NVOICE; i++)
                    if (slot_v[i] && i != tgt && slot_age[i] < old_age)
                        n_age[i] = slot_age[i] + 2'd1;
                n_v[tgt]   = 1'b1;
                n_key[tgt] = cap_key;
                n_per[tgt] = cap_per;
                n_age[tgt] = 2'd0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                n_held[tgt] = 1'b0;
`endif
            end
        end else if (hit) begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            if (cap_sus) begin
                n_held[hit_idx] = 1'b1;
            end else begin
`endif
                n_v[hit_idx]   = 1'b0;
                n_age[hit_idx] = 2'd0;
                for (int i = 0; i < NVOICE; i++)
                    if (slot_v[i] && slot_age[i] > slot_age[hit_idx])
                        n_age[i] = slot_age[i] - 2'd1;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            end
`endif
        end
    end

    // Compaction of the committed table; valid periods fill the outputs lowest slot first.
    always_comb begin
        pk = 0;
        for (int i = 0; i < NVOICE; i++) c_prd[i] = '0;
        for (int i = 0; i < NVOICE; i++) begin
            if (slot_v[i]) begin
                c_prd[pk] = slot_per[i];
                pk        = pk + 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            cap_on     <= 1'b0;
            cap_key    <= '0;
            cap_per    <= '0;
            steal_pend <= 1'b0;
            prd1       <= '0;
            prd2       <= '0;
            prd3       <= '0;
            notes      <= 2'd0;
            steal      <= 1'b0;
            for (int i = 0; i < NVOICE; i++) begin
                slot_v[i]   <= 1'b0;
                slot_key[i] <= '0;
                slot_per[i] <= '0;
                slot_age[i] <= 2'd0;
            end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            cap_sus  <= 1'b0;
            cap_rel  <= 1'b0;
            sus_q    <= 1'b0;
            rel_pend <= 1'b0;
            for (int i = 0; i < NVOICE; i++) slot_held[i] <= 1'b0;
`endif
        end else if (all_off) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            steal_pend <= 1'b0;
            prd1       <= '0;
            prd2       <= '0;
            prd3       <= '0;
            notes      <= 2'd0;
            steal      <= 1'b0;
            for (int i = 0; i < NVOICE; i++) begin
                slot_v[i]   <= 1'b0;
                slot_age[i] <= 2'd0;
            end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            sus_q    <= sustain;
            rel_pend <= 1'b0;
            for (int i = 0; i < NVOICE; i++) slot_held[i] <= 1'b0;
`endif
        end else begin
            steal <= 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            sus_q <= sustain;
            if (sus_q && !sustain) rel_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                    if (rel_pend) begin
                        cap_rel  <= 1'b1;
                        cap_on   <= 1'b0;
                        rel_pend <= 1'b0;
                        ready_q  <= 1'b0;
                        state    <= APPLY;
                    end else
`endif
                    if (accept) begin
                        cap_on  <= ev_on;
                        cap_key <= ev_key;
                        cap_per <= ev_period;
                        ready_q <= 1'b0;
                        state   <= APPLY;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        cap_rel <= 1'b0;
                        cap_sus <= sustain;
`endif
                    end
                end
                APPLY: begin
                    for (int i = 0; i < NVOICE; i++) begin
                        slot_v[i]   <= n_v[i];
                        slot_key[i] <= n_key[i];
                        slot_per[i] <= n_per[i];
                        slot_age[i] <= n_age[i];
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        slot_held[i] <= n_held[i];
`endif
                    end
                    steal_pend <= n_steal;
                    state      <= COMPACT;
                end
                COMPACT: begin
                    prd1    <= c_prd[0];
                    prd2    <= c_prd[1];
                    prd3    <= c_prd[2];
                    notes   <= c_cnt;
                    steal   <= steal_pend;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed and random check of voice_allocator against a slot/recency-list reference model.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_on = 1'b0;
    logic [6:0]  ev_key = '0;
    logic [31:0] ev_period = '0;
    logic        all_off = 1'b0;
    logic        ev_ready;
    logic [31:0] prd1, prd2, prd3;
    logic [1:0]  notes;
    logic        steal, busy;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    voice_allocator dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_key(ev_key), .ev_period(ev_period), .all_off(all_off),
        .prd1(prd1), .prd2(prd2), .prd3(prd3), .notes(notes), .steal(steal), .busy(busy)
    );

    // Reference model: slot contents plus a recency list of slot indices, newest first.
    bit          m_v   [3];
    logic [6:0]  m_key [3];
    logic [31:0] m_per [3];
    int          rec[$];
    bit          m_steal;

    function automatic logic [31:0] m_prd(input int n);
        int k = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_v[i]) begin
                if (k == n) return m_per[i];
                k++;
            end
        end
        return 32'd0;
    endfunction

    function automatic logic [1:0] m_notes();
        int c = 0;
        for (int i = 0; i < 3; i++) c += int'(m_v[i]);
        return 2'(c);
    endfunction

    function automatic void rec_remove(input int s);
        for (int j = 0; j < rec.size(); j++) begin
            if (rec[j] == s) begin
                rec.delete(j);
                return;
            end
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
        rec.delete();
        m_steal = 1'b0;
    endfunction

    function automatic void m_event(input bit on, input logic [6:0] key, input logic [31:0] per);
        int hit = -1;
        int slot = -1;
        m_steal = 1'b0;
        for (int i = 0; i < 3; i++)
            if (m_v[i] && m_key[i] == key && hit < 0) hit = i;
        if (on) begin
            if (per == 0) return;
            if (hit >= 0) slot = hit;
            else begin
                for (int i = 2; i >= 0; i--) if (!m_v[i]) slot = i;
                if (slot < 0) begin
                    slot = rec[rec.size() - 1];
                    m_steal = 1'b1;
                end
            end
            rec_remove(slot);
            rec.push_front(slot);
            m_v[slot] = 1'b1;
            m_key[slot] = key;
            m_per[slot] = per;
        end else if (hit >= 0) begin
            m_v[hit] = 1'b0;
            rec_remove(hit);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_prd1"}, prd1, m_prd(0));
        chk({tag, "_prd2"}, prd2, m_prd(1));
        chk({tag, "_prd3"}, prd3, m_prd(2));
        chk({tag, "_notes"}, 32'(notes), 32'(m_notes()));
    endtask

    // Full transaction: handshake, two held cycles, commit, then steal must drop.
    task automatic send(input bit on, input logic [6:0] key, input logic [31:0] per);
        int w = 0;
        @(negedge clk);
        while (!ev_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ev_ready) begin
            chk("ready_timeout", 32'(ev_ready), 32'd1);
            return;
        end
        ev_valid = 1'b1; ev_on = on; ev_key = key; ev_period = per;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        chk("ready_lo1", 32'(ev_ready), 32'd0);
        chk("busy_apply", 32'(busy), 32'd1);
        chk("hold_prd1", prd1, m_prd(0));
        @(negedge clk);
        chk("ready_lo2", 32'(ev_ready), 32'd0);
        chk("hold_notes", 32'(notes), 32'(m_notes()));
        m_event(on, key, per);
        @(negedge clk);
        chk("ready_hi", 32'(ev_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk_outputs("commit");
        chk("steal", 32'(steal), 32'(m_steal));
        @(negedge clk);
        chk("steal_drop", 32'(steal), 32'd0);
    endtask

    task automatic panic();
        @(negedge clk);
        all_off = 1'b1;
        #1 chk("ready_forced_lo", 32'(ev_ready), 32'd0);
        @(posedge clk);
        #1 all_off = 1'b0;
        m_clear();
        @(negedge clk);
        chk_outputs("panic");
        chk("panic_ready", 32'(ev_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m_clear();
        // Reset values
        #1;
        chk("rst_prd1", prd1, 32'd0);
        chk("rst_notes", 32'(notes), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ev_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_before_edge", 32'(ev_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(ev_ready), 32'd1);

        // Single note-on
        send(1'b1, 7'd10, 32'd1000);
        chk("t1_prd1", prd1, 32'd1000);

        // Three on, one off
        send(1'b1, 7'd11, 32'd2000);
        send(1'b1, 7'd12, 32'd3000);
        send(1'b0, 7'd11, 32'd0);
        chk("t2_prd2", prd2, 32'd3000);

        // Steal of the oldest voice
        panic();
        send(1'b1, 7'd10, 32'd1000);
        send(1'b1, 7'd11, 32'd2000);
        send(1'b1, 7'd12, 32'd3000);
        send(1'b1, 7'd13, 32'd4000);
        chk("t3_prd1", prd1, 32'd4000);

        // Refresh and zero-period note-on
        panic();
        send(1'b1, 7'd10, 32'd1000);
        send(1'b1, 7'd10, 32'd1500);
        chk("t4_prd1", prd1, 32'd1500);
        send(1'b1, 7'd11, 32'd0);

        // all_off the cycle after an accepted event
        send(1'b1, 7'd11, 32'd2000);
        send(1'b1, 7'd12, 32'd3000);
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd20; ev_period = 32'd7777;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        all_off = 1'b1;
        @(posedge clk);
        #1 all_off = 1'b0;
        m_clear();
        chk("t5_busy", 32'(busy), 32'd0);
        chk_outputs("t5");
        repeat (4) @(negedge clk);
        chk_outputs("t5_late");

        // Event offered while all_off is high is not taken
        all_off = 1'b1;
        ev_valid = 1'b1; ev_key = 7'd21; ev_period = 32'd5;
        #1 chk("t5_ready_forced", 32'(ev_ready), 32'd0);
        @(posedge clk);
        #1 begin all_off = 1'b0; ev_valid = 1'b0; end
        @(negedge clk);
        chk("t5_not_accepted", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk_outputs("t5_no_event");

        // Asynchronous reset in APPLY
        send(1'b1, 7'd30, 32'd111);
        send(1'b1, 7'd31, 32'd222);
        @(negedge clk);
        ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd32; ev_period = 32'd333;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_clear();
        #1;
        chk_outputs("t6_async");
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t6_ready_pre", 32'(ev_ready), 32'd0);
        @(negedge clk);
        chk("t6_ready_post", 32'(ev_ready), 32'd1);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 24) == 0) panic();
            else send($urandom_range(0, 2) != 0, 7'(10 + $urandom_range(0, 4)),
                      ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller between the key-event source and the three per-note waveform generators.
- Accepts note-on/note-off events through a valid/ready handshake and keeps a 3-entry voice table with age-based stealing.
- Publishes compacted periods prd1..prd3 and the active-note count `notes` in the format the output mixer consumes.

Parameters:
- NVOICE, 3, number of voice slots; the design is verified only at 3.
- KEYW, 7, key-identifier width.
- PRDW, 32, period width in clk cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- ev_valid  in  1  event present
- ev_ready  out  1  allocator can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_key  in  KEYW  key identifier
- ev_period  in  PRDW  note period (used on note-on only)
- all_off  in  1  panic: clear every voice
- prd1, prd2, prd3  out  PRDW  compacted voice periods
- notes  out  2  number of active voices, 0..3
- steal  out  1  one-cycle pulse when a voice was stolen
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high.
  - While reset is high: state=IDLE, all slots invalid, ages 0, prd1..3=0, notes=0, steal=0, busy=0.
  - ev_ready=1 from the first edge after reset deasserts.
- Slot fields: valid, key[KEYW], period[PRDW], age[1:0]. Age 0 is the newest; valid ages are always unique and within 0..count-1.
- FSM states:
  - IDLE: ev_ready=1. An event is accepted on an edge where ev_valid&ev_ready. The event fields are captured and the FSM goes to APPLY.
  - APPLY: ev_ready=0. The slot table is updated at this edge, then the FSM goes to COMPACT.
  - COMPACT: ev_ready=0. prd1..3, notes and steal are registered at this edge, then the FSM returns to IDLE.
- Latency and throughput: outputs change exactly 2 edges after the acceptance edge. At most one event per 3 cycles.
- Outputs hold their values between commits. Generators never see partial updates.
- Note-on rules, applied in APPLY, first match wins:
  1. ev_period==0: event ignored, table unchanged; COMPACT still runs.
  2. A valid slot already holds ev_key: its period is replaced and its age is set to 0. Valid slots with age below its old age get age+1.
  3. A free slot exists: the lowest-index free slot is filled with age 0. All other valid slots get age+1.
  4. All slots are valid: the slot with age NVOICE-1 is overwritten with age 0. All other slots get age+1. steal pulses high for the single cycle after the COMPACT edge.
- Note-off rules:
  - A matching valid slot is invalidated. Valid slots with age greater than its age get age-1.
  - No match: ignored, no error.
- Compaction in COMPACT:
  - Valid slots are packed in ascending slot-index order into prd1, prd2, prd3.
  - Unused outputs are 0.
  - notes = popcount(valid).
- all_off has priority over everything:
  - When sampled high on any edge, in any state: all slots are invalidated, prd1..3=0, notes=0, steal=0, and state=IDLE on that same edge.
  - An event in flight is discarded.
  - If ev_valid is also high in IDLE on that edge, the event is not accepted (ev_ready is forced 0 while all_off=1).
- busy = (state != IDLE).

Optional Feature:
- Macro: VOICE_ALLOCATOR_SUSTAIN_EN.
- When defined:
  - Adds input port `sustain` (1 bit) and a per-slot `held` flag.
  - A note-off matching a slot while sustain=1 sets held=1 instead of invalidating.
  - A note-on that refreshes a held slot clears held.
  - On the first IDLE cycle after a sustain falling edge, the FSM goes IDLE->APPLY->COMPACT with no event. Every held slot is released using the note-off age rules, then outputs are committed.
  - all_off also clears held.
  - Steal priority: held slots are stolen before unheld slots, oldest first.
- When undefined: no sustain port or held flags; behaviour exactly as above.

Test Plan:
1. Reset, then note-on key 10 period 1000 -> after 2 edges prd1=1000, prd2=prd3=0, notes=1; ev_ready low for 2 cycles.
2. Note-on keys 10/11/12 with periods 1000/2000/3000, then note-off key 11 -> prd1=1000, prd2=3000, prd3=0, notes=2; ages of keys 12,10 are 0,1.
3. Keys 10,11,12 on, then key 13 period 4000 on -> key 10 slot (slot 0) stolen: prd1=4000, prd2=2000, prd3=3000, notes=3, steal high exactly one cycle.
4. Key 10 on with 1000, then key 10 on with 1500 -> notes=1, prd1=1500, no steal; note-on with period 0 -> outputs unchanged.
5. Three voices active, all_off asserted the cycle after an event is accepted -> next edge prd1..3=0, notes=0, state IDLE; the discarded event never appears.
6. Reset asserted mid-APPLY with 2 voices active -> outputs 0 immediately (asynchronous); ev_ready=1 on the first edge after deassertion.
